cmd_frame_packer: RTL and testbench

CMD_FRAME_PACKER -- requirements
Module: cmd_frame_packer

---
 rtl/cmd_frame_packer.sv | 197 +++++++++++++++++++
 tb/tb_cmd_frame_packer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cmd_frame_packer.sv
// Packs host byte frames (header 8'b101000tt + 4 payload bytes, MSB first) into 34-bit
// command words queued in a first-word-fall-through FIFO. Define CMD_FRAME_CHECKSUM_EN to require a 6th XOR byte.
module cmd_frame_packer #(
  parameter int FIFO_LGDEPTH   = 2,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_rx_stb,
  input  logic [7:0]  i_rx_byte,
  output logic        o_cmd_stb,
  output logic [33:0] o_cmd_word,
  input  logic        i_cmd_busy,
  output logic        o_sync_err,
  output logic        o_ovfl,
  output logic        o_chk_err,
  output logic [7:0]  o_drop_cnt
);

  localparam int Depth = 1 << FIFO_LGDEPTH;
  localparam int PtrW  = FIFO_LGDEPTH + 1;
  localparam int TmoW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
  localparam logic [TmoW-1:0] TmoOne  = TmoW'(1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  // Without a checksum the last payload byte goes straight from the bus into the word,
  // so only the first three payload bytes need storage.
`ifdef CMD_FRAME_CHECKSUM_EN
  localparam int PayW = 32;
  typedef enum logic [1:0] {IDLE, DATA, CHK} state_e;
`else
  localparam int PayW = 24;
  typedef enum logic [1:0] {IDLE, DATA} state_e;
`endif

  state_e            state_q;
  logic [1:0]        byteIdx_q;
  logic [1:0]        type_q;
  logic [PayW-1:0]   payload_q;
  logic [TmoW-1:0]   tmoCnt_q;
  logic              syncErr_q;
  logic              ovfl_q;
  logic [7:0]        dropCnt_q;
`ifdef CMD_FRAME_CHECKSUM_EN
  logic [7:0]        csum_q;
  logic              chkErr_q;
`endif

  logic [33:0]       mem_q [Depth];
  logic [PtrW-1:0]   wrPtr_q, wrPtr_d;
  logic [PtrW-1:0]   rdPtr_q, rdPtr_d;

  logic              hdrByte;
  logic              tmoHit;
  logic              frameDone;
  logic              chkBad;
  logic              fifoEmpty;
  logic              fifoFull;
  logic              pop;
  logic              push;
  logic              overflow;
  logic              dropEvt;
  logic [33:0]       pushWord;

  assign hdrByte = (i_rx_byte[7:2] == 6'b101000);
  assign tmoHit  = (state_q != IDLE) && !i_rx_stb && (tmoCnt_q == TmoLast);

`ifdef CMD_FRAME_CHECKSUM_EN
  assign frameDone = (state_q == CHK) && i_rx_stb && (i_rx_byte == csum_q);
  assign chkBad    = (state_q == CHK) && i_rx_stb && (i_rx_byte != csum_q);
  assign pushWord  = {type_q, payload_q};
`else
  assign frameDone = (state_q == DATA) && i_rx_stb && (byteIdx_q == 2'd3);
  assign chkBad    = 1'b0;
  assign pushWord  = {type_q, payload_q, i_rx_byte};
`endif

  // Pointers carry one extra wrap bit so full and empty differ only in the MSB.
  assign fifoEmpty = (wrPtr_q == rdPtr_q);
  assign fifoFull  = (wrPtr_q[FIFO_LGDEPTH] != rdPtr_q[FIFO_LGDEPTH]) &&
                     (wrPtr_q[FIFO_LGDEPTH-1:0] == rdPtr_q[FIFO_LGDEPTH-1:0]);
  assign pop       = !fifoEmpty && !i_cmd_busy;
  assign push      = frameDone && (!fifoFull || pop);
  assign overflow  = frameDone && fifoFull && !pop;
  assign dropEvt   = tmoHit || overflow || chkBad;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (push) wrPtr_d = wrPtr_q + PtrOne;
    if (pop)  rdPtr_d = rdPtr_q + PtrOne;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      if (push) mem_q[wrPtr_q[FIFO_LGDEPTH-1:0]] <= pushWord;
    end
  end

  assign o_cmd_stb  = !fifoEmpty;
  assign o_cmd_word = fifoEmpty ? 34'h0 : mem_q[rdPtr_q[FIFO_LGDEPTH-1:0]];

  // A header byte seen mid-frame is plain payload; resync happens only through the timeout.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      byteIdx_q <= 2'd0;
      type_q    <= 2'd0;
      payload_q <= '0;
      tmoCnt_q  <= '0;
      syncErr_q <= 1'b0;
      ovfl_q    <= 1'b0;
      dropCnt_q <= 8'h00;
`ifdef CMD_FRAME_CHECKSUM_EN
      csum_q    <= 8'h00;
      chkErr_q  <= 1'b0;
`endif
    end else begin
      syncErr_q <= 1'b0;
      ovfl_q    <= overflow;
`ifdef CMD_FRAME_CHECKSUM_EN
      chkErr_q  <= chkBad;
`endif
      if (dropEvt && (dropCnt_q != 8'hFF)) dropCnt_q <= dropCnt_q + 8'd1;

      case (state_q)
        IDLE: begin
          tmoCnt_q <= '0;
          if (i_rx_stb) begin
            if (hdrByte) begin
              state_q   <= DATA;
              byteIdx_q <= 2'd0;
              type_q    <= i_rx_byte[1:0];
`ifdef CMD_FRAME_CHECKSUM_EN
              csum_q    <= i_rx_byte;
`endif
            end else begin
              syncErr_q <= 1'b1;
            end
          end
        end

        DATA: begin
          if (i_rx_stb) begin
            tmoCnt_q  <= '0;
            payload_q <= {payload_q[PayW-9:0], i_rx_byte};
            byteIdx_q <= byteIdx_q + 2'd1;
`ifdef CMD_FRAME_CHECKSUM_EN
            csum_q    <= csum_q ^ i_rx_byte;
            if (byteIdx_q == 2'd3) state_q <= CHK;
`else
            if (byteIdx_q == 2'd3) state_q <= IDLE;
`endif
          end else if (tmoHit) begin
            state_q   <= IDLE;
            syncErr_q <= 1'b1;
          end else begin
            tmoCnt_q  <= tmoCnt_q + TmoOne;
          end
        end

`ifdef CMD_FRAME_CHECKSUM_EN
        CHK: begin
          if (i_rx_stb) begin
            tmoCnt_q <= '0;
            state_q  <= IDLE;
          end else if (tmoHit) begin
            state_q   <= IDLE;
            syncErr_q <= 1'b1;
          end else begin
            tmoCnt_q  <= tmoCnt_q + TmoOne;
          end
        end
`endif

        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_sync_err = syncErr_q;
  assign o_ovfl     = ovfl_q;
  assign o_drop_cnt = dropCnt_q;
`ifdef CMD_FRAME_CHECKSUM_EN
  assign o_chk_err  = chkErr_q;
`else
  assign o_chk_err  = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_frame_packer.sv
// Directed bench for cmd_frame_packer: expected command words go into a scoreboard queue
// when a frame is sent and are popped whenever the DUT hands a word over.
module tb_cmd_frame_packer;

  localparam int Tmo = 12;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_rx_stb = 1'b0;
  logic [7:0]  i_rx_byte = 8'h00;
  logic        o_cmd_stb;
  logic [33:0] o_cmd_word;
  logic        i_cmd_busy = 1'b0;
  logic        o_sync_err;
  logic        o_ovfl;
  logic        o_chk_err;
  logic [7:0]  o_drop_cnt;

  logic [33:0] sb[$];
  int vecCnt  = 0;
  int errCnt  = 0;
  int syncCnt = 0;
  int ovflCnt = 0;
  int expDrop = 0;

  cmd_frame_packer #(.FIFO_LGDEPTH(2), .TIMEOUT_CYCLES(Tmo)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_rx_stb(i_rx_stb), .i_rx_byte(i_rx_byte),
    .o_cmd_stb(o_cmd_stb), .o_cmd_word(o_cmd_word), .i_cmd_busy(i_cmd_busy),
    .o_sync_err(o_sync_err), .o_ovfl(o_ovfl), .o_chk_err(o_chk_err), .o_drop_cnt(o_drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    vecCnt++;
    assert (obs === exp) else begin
      errCnt++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs only change 1 time unit after a rising edge, so the falling edge sees a stable
  // handshake: a word shown with busy low here is consumed on the next rising edge.
  always @(negedge i_clk) begin
    if (i_reset_n) begin
      if (o_sync_err === 1'b1) syncCnt++;
      if (o_ovfl === 1'b1) ovflCnt++;
      if (o_cmd_stb === 1'b1 && i_cmd_busy === 1'b0) begin
        if (sb.size() == 0) checkOutput("unexpected_word_stb", {33'b0, o_cmd_stb}, 34'h0);
        else checkOutput("cmd_word", o_cmd_word, sb.pop_front());
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] b);
    i_rx_stb  = 1'b1;
    i_rx_byte = b;
    @(posedge i_clk);
    #1;
    i_rx_stb  = 1'b0;
    i_rx_byte = 8'h00;
  endtask

  task automatic sendFrame(input logic [1:0] tt, input logic [31:0] pay, input bit expectPush,
                           input bit releaseBeforeLast);
    logic [7:0] b;
`ifdef CMD_FRAME_CHECKSUM_EN
    logic [7:0] cs;
    cs = {6'b101000, tt} ^ pay[31:24] ^ pay[23:16] ^ pay[15:8] ^ pay[7:0];
`endif
    applyStimulus({6'b101000, tt});
    for (int i = 0; i < 3; i++) begin
      b = pay[31-8*i -: 8];
      applyStimulus(b);
    end
`ifdef CMD_FRAME_CHECKSUM_EN
    applyStimulus(pay[7:0]);
    if (releaseBeforeLast) i_cmd_busy = 1'b0;
    applyStimulus(cs);
`else
    if (releaseBeforeLast) i_cmd_busy = 1'b0;
    applyStimulus(pay[7:0]);
`endif
    if (expectPush) sb.push_back({tt, pay});
  endtask

  task automatic waitDrain(input string tag);
    for (int c = 0; c < 40 && sb.size() != 0; c++) @(posedge i_clk);
    #1;
    checkOutput(tag, 34'(sb.size()), 34'h0);
  endtask

  initial begin
    #2;
    checkOutput("reset_cmd_stb", {33'b0, o_cmd_stb}, 34'h0);
    checkOutput("reset_cmd_word", o_cmd_word, 34'h0);
    checkOutput("reset_sync_err", {33'b0, o_sync_err}, 34'h0);
    checkOutput("reset_ovfl", {33'b0, o_ovfl}, 34'h0);
    checkOutput("reset_chk_err", {33'b0, o_chk_err}, 34'h0);
    checkOutput("reset_drop_cnt", 34'(o_drop_cnt), 34'h0);
    repeat (2) @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Basic frame, word must be visible one cycle after the last byte.
    sendFrame(2'd1, 32'h1234_5678, 1'b1, 1'b0);
    checkOutput("latency_stb", {33'b0, o_cmd_stb}, 34'h1);
    checkOutput("latency_word", o_cmd_word, 34'h1_1234_5678);
    waitDrain("drain_basic");
    checkOutput("consumed_stb", {33'b0, o_cmd_stb}, 34'h0);

    // Stray byte in IDLE.
    applyStimulus(8'h55);
    checkOutput("stray_sync_err", {33'b0, o_sync_err}, 34'h1);
    checkOutput("stray_drop_cnt", 34'(o_drop_cnt), 34'(expDrop));
    sendFrame(2'd0, 32'hDEAD_BEEF, 1'b1, 1'b0);
    waitDrain("drain_deadbeef");

    // Header-looking bytes inside a frame are payload.
    sendFrame(2'd0, 32'hA1A2_A3A1, 1'b1, 1'b0);
    waitDrain("drain_hdr_payload");
    checkOutput("hdr_payload_sync_cnt", 34'(syncCnt), 34'h1);

    // Overflow: four frames fill the FIFO while busy, the fifth is dropped.
    i_cmd_busy = 1'b1;
    for (int n = 1; n <= 4; n++) sendFrame(2'd2, 32'(n), 1'b1, 1'b0);
    sendFrame(2'd2, 32'h5, 1'b0, 1'b0);
    expDrop++;
    checkOutput("ovfl_pulse", {33'b0, o_ovfl}, 34'h1);
    checkOutput("ovfl_drop_cnt", 34'(o_drop_cnt), 34'(expDrop));
    checkOutput("busy_head_word", o_cmd_word, 34'h2_0000_0001);
    i_cmd_busy = 1'b0;
    waitDrain("drain_ovfl");
    checkOutput("ovfl_count", 34'(ovflCnt), 34'h1);

    // Full FIFO with a pop on the same edge as the push: no overflow.
    i_cmd_busy = 1'b1;
    for (int n = 0; n < 4; n++) sendFrame(2'd3, 32'h0000_00A0 + 32'(n), 1'b1, 1'b0);
    sendFrame(2'd3, 32'h0000_00A4, 1'b1, 1'b1);
    checkOutput("full_pop_ovfl", {33'b0, o_ovfl}, 34'h0);
    checkOutput("full_pop_drop_cnt", 34'(o_drop_cnt), 34'(expDrop));
    waitDrain("drain_full_pop");
    checkOutput("full_pop_ovfl_count", 34'(ovflCnt), 34'h1);

    // Inter-byte timeout on a partial frame.
    applyStimulus(8'hA3);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    repeat (Tmo - 1) @(posedge i_clk);
    #1;
    checkOutput("tmo_early_sync_err", {33'b0, o_sync_err}, 34'h0);
    @(posedge i_clk);
    #1;
    expDrop++;
    checkOutput("tmo_sync_err", {33'b0, o_sync_err}, 34'h1);
    checkOutput("tmo_drop_cnt", 34'(o_drop_cnt), 34'(expDrop));
    sendFrame(2'd3, 32'hCAFE_F00D, 1'b1, 1'b0);
    waitDrain("drain_after_tmo");

`ifdef CMD_FRAME_CHECKSUM_EN
    // Bad checksum byte.
    applyStimulus(8'hA1);
    applyStimulus(8'h12);
    applyStimulus(8'h34);
    applyStimulus(8'h56);
    applyStimulus(8'h78);
    applyStimulus(8'h00);
    expDrop++;
    checkOutput("chk_err_pulse", {33'b0, o_chk_err}, 34'h1);
    checkOutput("chk_err_stb", {33'b0, o_cmd_stb}, 34'h0);
    checkOutput("chk_err_drop_cnt", 34'(o_drop_cnt), 34'(expDrop));
`endif

    // Reset mid-frame with words queued.
    i_cmd_busy = 1'b1;
    sendFrame(2'd1, 32'h1111_1111, 1'b1, 1'b0);
    sendFrame(2'd1, 32'h2222_2222, 1'b1, 1'b0);
    applyStimulus(8'hA1);
    applyStimulus(8'h12);
    applyStimulus(8'h34);
    i_reset_n = 1'b0;
    #1;
    checkOutput("midreset_stb", {33'b0, o_cmd_stb}, 34'h0);
    checkOutput("midreset_word", o_cmd_word, 34'h0);
    checkOutput("midreset_drop_cnt", 34'(o_drop_cnt), 34'h0);
    sb.delete();
    expDrop = 0;
    @(posedge i_clk);
    #1;
    i_reset_n  = 1'b1;
    i_cmd_busy = 1'b0;
    sendFrame(2'd2, 32'h0BAD_C0DE, 1'b1, 1'b0);
    checkOutput("post_reset_stb", {33'b0, o_cmd_stb}, 34'h1);
    checkOutput("post_reset_word", o_cmd_word, 34'h2_0BAD_C0DE);
    waitDrain("drain_post_reset");
    checkOutput("final_drop_cnt", 34'(o_drop_cnt), 34'(expDrop));

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
